// File: rtl/mem_sched_pkg.sv
// Shared types for the memory port scheduler.
//   sched_state_t : arbitration / transfer FSM states
//   sched_src_t   : which requester owns the current transaction
//   word_t        : memory data word
package mem_sched_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } sched_state_t;

   typedef enum logic {
      SRC_INSTR = 1'b0,
      SRC_DATA  = 1'b1
   } sched_src_t;

   typedef logic [15:0] word_t;

   // Width of the starvation counter; covers STARVE_LIMIT up to 15.
   localparam int unsigned STARVE_W = 4;

endpackage

// File: rtl/sched_lat_timer.sv
// Read-latency timer for the scheduler's WAIT state.
// Loadable down-counter; done_o is the terminal-count compare (count == 0).
//   clk_i      : clock
//   rst_i      : async active-low reset
//   load_i     : load load_val_i into the counter
//   load_val_i : start value
//   en_i       : decrement enable (holds at zero)
//   done_o     : counter has reached zero
module sched_lat_timer #(
   parameter int unsigned CNT_W = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   input  logic             en_i,
   output logic             done_o
);

   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         cnt_q <= '0;
      end else if (load_i) begin
         cnt_q <= load_val_i;
      end else if (en_i && (cnt_q != '0)) begin
         cnt_q <= cnt_q - 1'b1;
      end
   end

   assign done_o = (cnt_q == '0);

endmodule

// File: rtl/mem_port_scheduler.sv
// Shares one 16-bit memory port between instruction fetch and data
// load/store, one outstanding transaction at a time. Data has priority;
// after STARVE_LIMIT consecutive data grants with a fetch waiting, the
// fetch is served.
//
//   state | meaning
//   ------+---------------------------------------------------------
//   IDLE  | arbitrate; latch address/wdata/source/direction on grant
//   ISSUE | one cycle: memory strobe + gnt pulse to the winner
//   WAIT  | read only: MEM_LATENCY cycles, capture mem_value_i on last
//   DONE  | one cycle: instr_rvalid_o or data_ack_o pulse
//
// Ports:
//   clk_i, rst_i                          : clock, async active-low reset
//   instr_req_i/addr_i/flush_i            : fetch request side
//   instr_gnt_o/rvalid_o/rdata_o          : fetch response side
//   data_re_i/we_i/addr_i/wdata_i         : load/store request side
//   data_gnt_o/ack_o/rdata_o              : load/store response side
//   busy_o                                : FSM not in IDLE
//   mem_value_i, mem_addr_o, mem_value_o,
//   mem_rd_en_o, mem_wr_en_o, mem_enable_o: memory pins
module mem_port_scheduler
   import mem_sched_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH   = 8,
   parameter int unsigned MEM_LATENCY  = 2,
   parameter int unsigned STARVE_LIMIT = 3
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  instr_req_i,
   input  logic [31:0]           instr_addr_i,
   input  logic                  instr_flush_i,
   output logic                  instr_gnt_o,
   output logic                  instr_rvalid_o,
   output logic [15:0]           instr_rdata_o,
   input  logic                  data_re_i,
   input  logic                  data_we_i,
   input  logic [31:0]           data_addr_i,
   input  logic [15:0]           data_wdata_i,
   output logic                  data_gnt_o,
   output logic                  data_ack_o,
   output logic [15:0]           data_rdata_o,
   output logic                  busy_o,
   input  logic [15:0]           mem_value_i,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic [15:0]           mem_value_o,
   output logic                  mem_rd_en_o,
   output logic                  mem_wr_en_o,
   output logic                  mem_enable_o
);

   localparam int unsigned LAT_W = $clog2(MEM_LATENCY + 1);
   // Timer starts at MEM_LATENCY-1 so it hits zero in the last WAIT cycle.
   localparam logic [LAT_W-1:0]    LAT_LOAD   = LAT_W'(MEM_LATENCY - 1);
   localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

   sched_state_t          state_q, state_d;
   sched_src_t            src_q;
   logic                  wr_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   word_t                 wdata_q;
   word_t                 rdata_q;
   logic [STARVE_W-1:0]   starve_q;
   logic                  flush_q;

   logic data_req;
   logic grant_data;
   logic grant_instr;
   logic tmr_load;
   logic tmr_done;

   // Upper address bits are deliberately dropped.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{instr_addr_i[31:ADDR_WIDTH], data_addr_i[31:ADDR_WIDTH]};

   assign data_req = data_re_i | data_we_i;

   sched_lat_timer #(
      .CNT_W (LAT_W)
   ) u_lat_timer (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .load_i     (tmr_load),
      .load_val_i (LAT_LOAD),
      .en_i       (state_q == WAIT),
      .done_o     (tmr_done)
   );

   always_comb begin
      state_d     = state_q;
      grant_data  = 1'b0;
      grant_instr = 1'b0;
      tmr_load    = 1'b0;
      case (state_q)
         IDLE: begin
            if (data_req && ((starve_q < STARVE_MAX) || !instr_req_i)) begin
               grant_data = 1'b1;
               state_d    = ISSUE;
            end else if (instr_req_i) begin
               grant_instr = 1'b1;
               state_d     = ISSUE;
            end
         end
         ISSUE: begin
            if (wr_q) begin
               state_d = DONE;
            end else begin
               tmr_load = 1'b1;
               state_d  = WAIT;
            end
         end
         WAIT: begin
            if (tmr_done) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q  <= IDLE;
         src_q    <= SRC_INSTR;
         wr_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         starve_q <= '0;
         flush_q  <= 1'b0;
      end else begin
         state_q <= state_d;

         if (grant_data || grant_instr) begin
            src_q   <= grant_data ? SRC_DATA : SRC_INSTR;
            // Simultaneous read and write requests resolve to a write.
            wr_q    <= grant_data & data_we_i;
            addr_q  <= grant_data ? data_addr_i[ADDR_WIDTH-1:0]
                                  : instr_addr_i[ADDR_WIDTH-1:0];
            wdata_q <= data_wdata_i;
         end

         if ((state_q == WAIT) && tmr_done) begin
            rdata_q <= mem_value_i;
         end

         if (state_q == IDLE) begin
            if (!instr_req_i || grant_instr) begin
               starve_q <= '0;
            end else if (grant_data && (starve_q < STARVE_MAX)) begin
               starve_q <= starve_q + 1'b1;
            end
         end

         if (state_q == IDLE) begin
            flush_q <= 1'b0;
         end else if ((src_q == SRC_INSTR) && instr_flush_i) begin
            flush_q <= 1'b1;
         end
      end
   end

   assign busy_o       = (state_q != IDLE);
   assign mem_rd_en_o  = (state_q == ISSUE) & ~wr_q;
   assign mem_wr_en_o  = (state_q == ISSUE) &  wr_q;
   assign mem_enable_o = (state_q == ISSUE);
   assign mem_addr_o   = addr_q;
   assign mem_value_o  = wdata_q;

   assign instr_gnt_o  = (state_q == ISSUE) && (src_q == SRC_INSTR);
   assign data_gnt_o   = (state_q == ISSUE) && (src_q == SRC_DATA);

   // A flush arriving in the DONE cycle itself must still kill the pulse.
   assign instr_rvalid_o = (state_q == DONE) && (src_q == SRC_INSTR) &&
                           !flush_q && !instr_flush_i;
   assign data_ack_o     = (state_q == DONE) && (src_q == SRC_DATA);

   assign instr_rdata_o = rdata_q;
   assign data_rdata_o  = rdata_q;

endmodule

// File: tb/tb_mem_port_scheduler.sv
`timescale 1ns/1ps
module tb_mem_port_scheduler;

   localparam int unsigned AW  = 8;
   localparam int unsigned LAT = 2;
   localparam int unsigned LIM = 3;

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic          instr_req_i;
   logic [31:0]   instr_addr_i;
   logic          instr_flush_i;
   logic          instr_gnt_o;
   logic          instr_rvalid_o;
   logic [15:0]   instr_rdata_o;
   logic          data_re_i;
   logic          data_we_i;
   logic [31:0]   data_addr_i;
   logic [15:0]   data_wdata_i;
   logic          data_gnt_o;
   logic          data_ack_o;
   logic [15:0]   data_rdata_o;
   logic          busy_o;
   logic [15:0]   mem_value_i;
   logic [AW-1:0] mem_addr_o;
   logic [15:0]   mem_value_o;
   logic          mem_rd_en_o;
   logic          mem_wr_en_o;
   logic          mem_enable_o;

   always #5 clk_i = ~clk_i;

   mem_port_scheduler #(
      .ADDR_WIDTH   (AW),
      .MEM_LATENCY  (LAT),
      .STARVE_LIMIT (LIM)
   ) dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .instr_req_i    (instr_req_i),
      .instr_addr_i   (instr_addr_i),
      .instr_flush_i  (instr_flush_i),
      .instr_gnt_o    (instr_gnt_o),
      .instr_rvalid_o (instr_rvalid_o),
      .instr_rdata_o  (instr_rdata_o),
      .data_re_i      (data_re_i),
      .data_we_i      (data_we_i),
      .data_addr_i    (data_addr_i),
      .data_wdata_i   (data_wdata_i),
      .data_gnt_o     (data_gnt_o),
      .data_ack_o     (data_ack_o),
      .data_rdata_o   (data_rdata_o),
      .busy_o         (busy_o),
      .mem_value_i    (mem_value_i),
      .mem_addr_o     (mem_addr_o),
      .mem_value_o    (mem_value_o),
      .mem_rd_en_o    (mem_rd_en_o),
      .mem_wr_en_o    (mem_wr_en_o),
      .mem_enable_o   (mem_enable_o)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Staged stimulus, applied at the next negedge by tick().
   bit          stg_rst, stg_ireq, stg_flush, stg_dre, stg_dwe;
   logic [31:0] stg_iaddr, stg_daddr;
   logic [15:0] stg_wdata;

   // Transaction-level reference: a grant at cycle k is issued at k+1 and
   // completes at k+2 (write) or k+LAT+2 (read); arbitration resumes after.
   logic [15:0] mem [256];
   int          free_at = 0;
   int          starve  = 0;
   bit          t_valid = 0, t_is_d, t_wr, t_flush;
   logic [7:0]  t_addr;
   logic [15:0] t_wdata, t_val;
   int          t_issue, t_done;
   logic [15:0] exp_rdata = '0;

   task automatic tick();
      bit         idle, gd, gi, iss, dn, exp_busy;
      logic [7:0] exp_ctl, got_ctl;
      @(negedge clk_i);
      cyc++;
      rst_i         = stg_rst;
      instr_req_i   = stg_ireq;
      instr_addr_i  = stg_iaddr;
      instr_flush_i = stg_flush;
      data_re_i     = stg_dre;
      data_we_i     = stg_dwe;
      data_addr_i   = stg_daddr;
      data_wdata_i  = stg_wdata;

      if (!stg_rst) begin
         t_valid   = 0;
         starve    = 0;
         exp_rdata = '0;
         free_at   = 0;
      end
      idle     = (cyc >= free_at);
      exp_busy = stg_rst && !idle;
      if (stg_rst) begin
         if (idle) begin
            gd = (stg_dre || stg_dwe) && ((starve < LIM) || !stg_ireq);
            gi = !gd && stg_ireq;
            if (gd && stg_ireq && starve < LIM) starve++;
            if (gi || !stg_ireq) starve = 0;
            if (gd || gi) begin
               t_valid = 1;
               t_is_d  = gd;
               t_wr    = gd && stg_dwe;
               t_addr  = gd ? stg_daddr[7:0] : stg_iaddr[7:0];
               t_wdata = stg_wdata;
               t_val   = mem[t_addr];
               t_flush = 0;
               t_issue = cyc + 1;
               t_done  = t_wr ? cyc + 2 : cyc + LAT + 2;
               free_at = t_done + 1;
            end
         end else if (t_valid && !t_is_d && stg_flush && cyc >= t_issue && cyc <= t_done) begin
            t_flush = 1;
         end
      end

      iss = stg_rst && t_valid && (cyc == t_issue);
      dn  = stg_rst && t_valid && (cyc == t_done);
      if (dn && !t_wr) exp_rdata = t_val;
      exp_ctl = {exp_busy, iss && !t_is_d, iss && t_is_d, dn && !t_is_d && !t_flush,
                 dn && t_is_d, iss && !t_wr, iss && t_wr, iss};

      if (stg_rst && t_valid && !t_wr && (cyc == t_issue + LAT)) mem_value_i = t_val;
      else                                                       mem_value_i = 16'($urandom);

      #1;
      got_ctl = {busy_o, instr_gnt_o, data_gnt_o, instr_rvalid_o, data_ack_o,
                 mem_rd_en_o, mem_wr_en_o, mem_enable_o};
      check_eq("ctl{busy,igt,dgt,irv,dack,rd,wr,en}", 32'(got_ctl), 32'(exp_ctl));
      check_eq("instr_rdata", 32'(instr_rdata_o), 32'(exp_rdata));
      check_eq("data_rdata", 32'(data_rdata_o), 32'(exp_rdata));
      if (iss) check_eq("mem_addr", 32'(mem_addr_o), 32'(t_addr));
      if (iss && t_wr) check_eq("mem_value_o", 32'(mem_value_o), 32'(t_wdata));
   endtask

   task automatic stage_idle();
      stg_rst   = 1;
      stg_ireq  = 0;
      stg_flush = 0;
      stg_dre   = 0;
      stg_dwe   = 0;
   endtask

   task automatic run_idle(input int n);
      stage_idle();
      repeat (n) tick();
   endtask

   initial begin
      logic [7:0] seq;
      int         n_gnt;

      for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
      mem[8'h12] = 16'hA5C3;

      rst_i = 0; instr_req_i = 0; instr_addr_i = '0; instr_flush_i = 0;
      data_re_i = 0; data_we_i = 0; data_addr_i = '0; data_wdata_i = '0;
      mem_value_i = '0;
      stg_iaddr = '0; stg_daddr = '0; stg_wdata = '0;
      stage_idle();
      stg_rst = 0;
      repeat (2) tick();
      check_eq("reset_busy", 32'(busy_o), 32'd0);
      check_eq("reset_rdata", 32'(instr_rdata_o), 32'd0);
      check_eq("reset_addr", 32'(mem_addr_o), 32'd0);
      run_idle(3);

      // Fetch read of 0x12
      stg_ireq = 1; stg_iaddr = 32'h0000_0012;
      tick();
      stg_ireq = 0;
      tick();
      check_eq("fetch_rd_en", 32'(mem_rd_en_o), 32'd1);
      check_eq("fetch_addr", 32'(mem_addr_o), 32'h12);
      tick(); tick(); tick();
      check_eq("fetch_rvalid", 32'(instr_rvalid_o), 32'd1);
      check_eq("fetch_rdata", 32'(instr_rdata_o), 32'hA5C3);
      run_idle(2);

      // Data write 0x40 <- 0x1234
      stg_dwe = 1; stg_daddr = 32'h40; stg_wdata = 16'h1234;
      tick();
      stage_idle();
      tick();
      check_eq("wr_en", 32'(mem_wr_en_o), 32'd1);
      check_eq("wr_value", 32'(mem_value_o), 32'h1234);
      tick();
      check_eq("wr_ack", 32'(data_ack_o), 32'd1);
      tick();
      check_eq("wr_busy_after", 32'(busy_o), 32'd0);
      run_idle(2);

      // Both requesters held: starvation guard interleaves fetches
      stg_ireq = 1; stg_iaddr = 32'h0000_0030;
      stg_dre  = 1; stg_daddr = 32'h0000_0050;
      seq = '0; n_gnt = 0;
      for (int i = 0; i < 80 && n_gnt < 8; i++) begin
         tick();
         if (instr_gnt_o || data_gnt_o) begin
            seq = {seq[6:0], instr_gnt_o};
            n_gnt++;
         end
      end
      check_eq("starve_grant_count", 32'(n_gnt), 32'd8);
      check_eq("starve_grant_order", 32'(seq), 32'h11);
      run_idle(6);

      // Flush during WAIT suppresses rvalid, next fetch is normal
      stg_ireq = 1; stg_iaddr = 32'h0000_0021;
      tick();
      stg_ireq = 0;
      tick();
      check_eq("flush_rd_en", 32'(mem_rd_en_o), 32'd1);
      stg_flush = 1;
      tick();
      stg_flush = 0;
      tick(); tick();
      check_eq("flush_no_rvalid", 32'(instr_rvalid_o), 32'd0);
      tick();
      stg_ireq = 1; stg_iaddr = 32'h0000_0022;
      tick();
      stg_ireq = 0;
      tick(); tick(); tick(); tick();
      check_eq("post_flush_rvalid", 32'(instr_rvalid_o), 32'd1);
      check_eq("post_flush_rdata", 32'(instr_rdata_o), 32'(mem[8'h22]));
      run_idle(2);

      // Reset during WAIT
      stg_ireq = 1; stg_iaddr = 32'h0000_0033;
      tick();
      stg_ireq = 0;
      tick();
      stg_rst = 0;
      tick();
      check_eq("rst_wait_busy", 32'(busy_o), 32'd0);
      check_eq("rst_wait_en", 32'(mem_enable_o), 32'd0);
      stg_rst = 1;
      for (int i = 0; i < 6; i++) begin
         tick();
         check_eq("rst_no_resp", 32'(instr_rvalid_o | data_ack_o), 32'd0);
      end

      // Reset during ISSUE of a write: strobe must drop at once
      stg_dwe = 1; stg_daddr = 32'h0000_0044; stg_wdata = 16'h7E7E;
      tick();
      stage_idle();
      stg_rst = 0;
      tick();
      check_eq("rst_issue_wr_en", 32'(mem_wr_en_o), 32'd0);
      run_idle(3);

      // Read and write together resolve to a write
      stg_dre = 1; stg_dwe = 1; stg_daddr = 32'hFFFF_FF55; stg_wdata = 16'hBEEF;
      tick();
      stage_idle();
      tick();
      check_eq("rw_wr_en", 32'(mem_wr_en_o), 32'd1);
      check_eq("rw_rd_en", 32'(mem_rd_en_o), 32'd0);
      check_eq("rw_trunc_addr", 32'(mem_addr_o), 32'h55);
      tick();
      check_eq("rw_ack", 32'(data_ack_o), 32'd1);
      run_idle(2);

      // Randomised traffic with occasional flush and reset
      for (int i = 0; i < 3000; i++) begin
         stg_rst   = ($urandom_range(0, 399) != 0);
         stg_ireq  = ($urandom_range(0, 3) != 0);
         stg_iaddr = $urandom;
         stg_dre   = ($urandom_range(0, 2) == 0);
         stg_dwe   = ($urandom_range(0, 3) == 0);
         stg_daddr = $urandom;
         stg_wdata = 16'($urandom);
         stg_flush = ($urandom_range(0, 7) == 0);
         tick();
      end
      run_idle(8);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
